// File: rtl/divsign_ctrl.sv
// divsign_ctrl: RV32M DIV/DIVU/REM/REMU issue stage around a 32-bit iterative unsigned divider core.
// Optional macro DIVSIGN_FASTSPECIAL_EN: divide-by-zero / signed-overflow results bypass the core.
module divsign_ctrl #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TAGW = 5
) (
    input  logic            clk,
    input  logic            cpurst,
    input  logic            div_req,
    output logic            div_ready,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] div_rs1,
    input  logic [XLEN-1:0] div_rs2,
    input  logic [TAGW-1:0] div_tag,
    input  logic            div_flush,
    output logic [XLEN-1:0] core_dividend,
    output logic [XLEN-1:0] core_divider,
    output logic            core_diven_p,
    output logic            core_div0,
    output logic            core_ovflow,
    input  logic            core_valid,
    input  logic [XLEN-1:0] core_quo,
    input  logic [XLEN-1:0] core_rem,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic [TAGW-1:0] res_tag
);

    localparam int unsigned    MSB  = XLEN - 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

`ifdef DIVSIGN_FASTSPECIAL_EN
    localparam bit FastSpecial = 1'b1;
`else
    localparam bit FastSpecial = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE,
        S_FLUSH
    } state_e;

    state_e          state_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] rs1_q;
    logic [TAGW-1:0] tag_q;
    logic            negq_q;
    logic            negr_q;

    logic            req_signed_c;
    logic            div0_c;
    logic            ovf_c;
    logic            special_c;
    logic [XLEN-1:0] mag1_c;
    logic [XLEN-1:0] mag2_c;

    // Request decode: magnitudes and special-case detection on the incoming operands.
    always_comb begin
        req_signed_c = ~div_op[0];
        div0_c       = (div_rs2 == '0);
        ovf_c        = req_signed_c && (div_rs1 == SMIN) && (div_rs2 == '1);
        special_c    = FastSpecial && (div0_c || ovf_c);
        mag1_c       = (req_signed_c && div_rs1[MSB]) ? ('0 - div_rs1) : div_rs1;
        mag2_c       = (req_signed_c && div_rs2[MSB]) ? ('0 - div_rs2) : div_rs2;
    end

    // Special results take priority over the core output; otherwise apply sign correction.
    function automatic logic [XLEN-1:0] fix_result(
        input logic [1:0]      op,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem,
        input logic [XLEN-1:0] rs1,
        input logic            div0,
        input logic            ovf,
        input logic            negq,
        input logic            negr
    );
        logic [XLEN-1:0] r;
        if (div0) begin
            r = op[1] ? rs1 : '1;
        end else if (ovf) begin
            r = op[1] ? '0 : SMIN;
        end else if (op[1]) begin
            r = negr ? ('0 - rem) : rem;
        end else begin
            r = negq ? ('0 - quo) : quo;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state_q       <= S_IDLE;
            div_ready     <= 1'b1;
            core_diven_p  <= 1'b0;
            core_div0     <= 1'b0;
            core_ovflow   <= 1'b0;
            core_dividend <= '0;
            core_divider  <= '0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_tag       <= '0;
            op_q          <= '0;
            rs1_q         <= '0;
            tag_q         <= '0;
            negq_q        <= 1'b0;
            negr_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_req && !div_flush) begin
                        op_q          <= div_op;
                        rs1_q         <= div_rs1;
                        tag_q         <= div_tag;
                        negq_q        <= req_signed_c && (div_rs1[MSB] ^ div_rs2[MSB]);
                        negr_q        <= req_signed_c && div_rs1[MSB];
                        core_dividend <= mag1_c;
                        core_divider  <= mag2_c;
                        core_div0     <= div0_c && !FastSpecial;
                        core_ovflow   <= ovf_c && !FastSpecial;
                        div_ready     <= 1'b0;
                        if (special_c) begin
                            res_data  <= fix_result(div_op, '0, '0, div_rs1, div0_c, ovf_c, 1'b0, 1'b0);
                            res_tag   <= div_tag;
                            res_valid <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            core_diven_p <= 1'b1;
                            state_q      <= S_START;
                        end
                    end
                end
                S_START: begin
                    core_diven_p <= 1'b0;
                    state_q      <= div_flush ? S_FLUSH : S_WAIT;
                end
                S_WAIT: begin
                    // A flush coinciding with core_valid retires the killed op right here;
                    // waiting in FLUSH would need a second core_valid that never comes.
                    if (core_valid) begin
                        if (div_flush) begin
                            div_ready <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            res_data  <= fix_result(op_q, core_quo, core_rem, rs1_q,
                                                    core_div0, core_ovflow, negq_q, negr_q);
                            res_tag   <= tag_q;
                            res_valid <= 1'b1;
                            state_q   <= S_DONE;
                        end
                    end else if (div_flush) begin
                        state_q <= S_FLUSH;
                    end
                end
                S_DONE: begin
                    if (div_flush || res_ready) begin
                        res_valid <= 1'b0;
                        div_ready <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (core_valid) begin
                        div_ready <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    div_ready <= 1'b1;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divsign_ctrl.sv
// Bench for divsign_ctrl: behavioural divider-core model, vector table, directed corner sequences
// and randomized operations checked against an arithmetic reference.
module tb_divsign_ctrl;

`ifdef DIVSIGN_FASTSPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk;
    logic        cpurst;
    logic        div_req;
    logic        div_ready;
    logic [1:0]  div_op;
    logic [31:0] div_rs1;
    logic [31:0] div_rs2;
    logic [4:0]  div_tag;
    logic        div_flush;
    logic [31:0] core_dividend;
    logic [31:0] core_divider;
    logic        core_diven_p;
    logic        core_div0;
    logic        core_ovflow;
    logic        core_valid;
    logic [31:0] core_quo;
    logic [31:0] core_rem;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_tag;

    int checks = 0;
    int errors = 0;

    divsign_ctrl #(.XLEN(32), .TAGW(5)) dut (
        .clk(clk), .cpurst(cpurst),
        .div_req(div_req), .div_ready(div_ready), .div_op(div_op),
        .div_rs1(div_rs1), .div_rs2(div_rs2), .div_tag(div_tag), .div_flush(div_flush),
        .core_dividend(core_dividend), .core_divider(core_divider),
        .core_diven_p(core_diven_p), .core_div0(core_div0), .core_ovflow(core_ovflow),
        .core_valid(core_valid), .core_quo(core_quo), .core_rem(core_rem),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int msb_idx(input logic [31:0] x);
        for (int i = 31; i >= 0; i--) if (x[i]) return i;
        return 0;
    endfunction

    // Divider core stand-in: 32-k iteration cycles, one cycle when flagged special.
    int unsigned cm_cnt;
    bit          cm_busy;
    logic [31:0] cm_a, cm_b;
    always @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            cm_busy <= 1'b0; cm_cnt <= 0; cm_a <= '0; cm_b <= '0;
            core_valid <= 1'b0; core_quo <= '0; core_rem <= '0;
        end else begin
            core_valid <= 1'b0;
            if (core_diven_p) begin
                cm_busy <= 1'b1;
                cm_a    <= core_dividend;
                cm_b    <= core_divider;
                cm_cnt  <= (core_div0 || core_ovflow) ? 0 : 32'(31 - msb_idx(core_divider));
            end else if (cm_busy) begin
                if (cm_cnt == 0) begin
                    cm_busy    <= 1'b0;
                    core_valid <= 1'b1;
                    core_quo   <= (cm_b == 0) ? 32'hFFFF_FFFF : cm_a / cm_b;
                    core_rem   <= (cm_b == 0) ? cm_a : cm_a % cm_b;
                end else begin
                    cm_cnt <= cm_cnt - 1;
                end
            end
        end
    end

    // Reference: RISC-V divide semantics directly from the ISA rules.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, b);
        logic signed [31:0] sa, sb;
        sa = a; sb = b;
        case (op)
            2'd0: if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                  else return 32'(sa / sb);
            2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2: if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                  else return 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] mag(input logic [1:0] op, input logic [31:0] x);
        return (!op[0] && x[31]) ? (32'd0 - x) : x;
    endfunction

    function automatic bit is_ovf(input logic [1:0] op, input logic [31:0] a, b);
        return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, b);
        if (b == 0 || is_ovf(op, a, b)) return FAST ? 1 : 4;
        return 4 + 31 - msb_idx(mag(op, b));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, b, input logic [4:0] tag);
        @(negedge clk);
        div_req = 1'b1; div_op = op; div_rs1 = a; div_rs2 = b; div_tag = tag;
        @(posedge clk); #1;
        div_req = 1'b0;
        div_op = 2'($urandom); div_rs1 = $urandom; div_rs2 = $urandom; div_tag = 5'($urandom);
    endtask

    task automatic wait_valid(output int lat, output int pulses);
        lat = 1; pulses = int'(core_diven_p);
        while (!res_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            pulses += int'(core_diven_p);
        end
    endtask

    task automatic take_result(input logic [31:0] exp_d, input logic [4:0] exp_t,
                               input int exp_l, input int exp_p, input string nm);
        int lat, pulses;
        wait_valid(lat, pulses);
        chk({nm, "_valid"}, 32'(res_valid), 32'd1);
        if (exp_l > 0) chk({nm, "_latency"}, 32'(lat), 32'(exp_l));
        if (exp_p >= 0) chk({nm, "_starts"}, 32'(pulses), 32'(exp_p));
        chk({nm, "_data"}, res_data, exp_d);
        chk({nm, "_tag"}, 32'(res_tag), 32'(exp_t));
        @(negedge clk); res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
        chk({nm, "_valid_drop"}, 32'(res_valid), 32'd0);
        chk({nm, "_ready_back"}, 32'(div_ready), 32'd1);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, b, input logic [4:0] tag,
                         input logic [31:0] exp_d, exp_dvd, exp_dvs, input string nm);
        bit spec;
        spec = (b == 0) || is_ovf(op, a, b);
        @(negedge clk);
        chk({nm, "_ready"}, 32'(div_ready), 32'd1);
        issue(op, a, b, tag);
        chk({nm, "_dividend"}, core_dividend, exp_dvd);
        chk({nm, "_divider"}, core_divider, exp_dvs);
        chk({nm, "_div0"}, 32'(core_div0), 32'(!FAST && b == 0));
        chk({nm, "_ovflow"}, 32'(core_ovflow), 32'(!FAST && is_ovf(op, a, b)));
        take_result(exp_d, tag, exp_lat(op, a, b), (FAST && spec) ? 0 : 1, nm);
    endtask

    task automatic flush_watch(input string nm);
        int rv, n;
        bit seen;
        rv = 0; n = 0; seen = 1'b0;
        while (!seen && n < 64) begin
            @(posedge clk); #1;
            n++;
            if (core_valid) seen = 1'b1;
            rv += int'(res_valid);
        end
        chk({nm, "_core_done"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        rv += int'(res_valid);
        chk({nm, "_ready"}, 32'(div_ready), 32'd1);
        chk({nm, "_no_result"}, 32'(rv), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, exp_d, exp_dvd, exp_dvs;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int lat, pulses;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rtag;

        vecs[0]  = '{2'd0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'd7,        32'd2};
        vecs[1]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'd7,        32'd2};
        vecs[2]  = '{2'd3, 32'd100,       32'd7,        32'd2,         32'd100,      32'd7};
        vecs[3]  = '{2'd1, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
        vecs[4]  = '{2'd0, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'd5,        32'd0};
        vecs[5]  = '{2'd2, 32'd5,         32'd0,        32'd5,         32'd5,        32'd0};
        vecs[6]  = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'd1};
        vecs[7]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 32'd1};
        vecs[8]  = '{2'd1, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'd5,        32'd0};
        vecs[9]  = '{2'd3, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'h1234_5678, 32'd0};
        vecs[10] = '{2'd0, 32'h8000_0000, 32'd2,        32'hC000_0000, 32'h8000_0000, 32'd2};
        vecs[11] = '{2'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd8,       32'd3};
        vecs[12] = '{2'd0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd7,       32'd2};
        vecs[13] = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 32'hFFFF_FFFF};
        vecs[14] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'd7,        32'd2};
        vecs[15] = '{2'd0, 32'd0,         32'd5,        32'd0,         32'd0,        32'd5};

        cpurst = 1'b1; div_req = 1'b0; div_op = '0; div_rs1 = '0; div_rs2 = '0; div_tag = '0;
        div_flush = 1'b0; res_ready = 1'b0;
        #7;
        chk("rst_ready", 32'(div_ready), 32'd1);
        chk("rst_diven", 32'(core_diven_p), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_div0", 32'(core_div0), 32'd0);
        chk("rst_ovflow", 32'(core_ovflow), 32'd0);
        chk("rst_dividend", core_dividend, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_tag", 32'(res_tag), 32'd0);
        #10 cpurst = 1'b0;

        for (int i = 0; i < 16; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), vecs[i].exp_d,
                  vecs[i].exp_dvd, vecs[i].exp_dvs, $sformatf("vec%0d", i));

        // Result held under backpressure while a new request waits.
        issue(2'd1, 32'd50, 32'd5, 5'd7);
        wait_valid(lat, pulses);
        chk("hold_first_valid", 32'(res_valid), 32'd1);
        @(negedge clk);
        div_req = 1'b1; div_op = 2'd1; div_rs1 = 32'd9; div_rs2 = 32'd3; div_tag = 5'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", res_data, 32'd10);
            chk("hold_tag", 32'(res_tag), 32'd7);
            chk("hold_ready", 32'(div_ready), 32'd0);
            chk("hold_no_start", 32'(core_diven_p), 32'd0);
        end
        @(negedge clk); res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
        chk("hold_release_valid", 32'(res_valid), 32'd0);
        chk("hold_release_idle", 32'(div_ready), 32'd1);
        chk("hold_release_no_start", 32'(core_diven_p), 32'd0);
        @(posedge clk); #1;
        div_req = 1'b0;
        chk("hold_next_accept", 32'(div_ready), 32'd0);
        take_result(32'd3, 5'd3, 4 + 31 - 1, 1, "hold_second");

        // Flush five cycles into WAIT, then a clean follow-up op.
        issue(2'd0, 32'd100, 32'd3, 5'd1);
        for (int i = 0; i < 6; i++) @(posedge clk);
        @(negedge clk); div_flush = 1'b1;
        @(posedge clk); #1; div_flush = 1'b0;
        flush_watch("flush_wait");
        do_op(2'd0, 32'd100, 32'd3, 5'd2, 32'd33, 32'd100, 32'd3, "after_flush");

        // Flush during START.
        issue(2'd3, 32'd77, 32'd10, 5'd4);
        @(negedge clk); div_flush = 1'b1;
        @(posedge clk); #1; div_flush = 1'b0;
        flush_watch("flush_start");

        // Flush while the result sits in DONE.
        issue(2'd1, 32'd20, 32'd4, 5'd5);
        wait_valid(lat, pulses);
        chk("flush_done_valid", 32'(res_valid), 32'd1);
        @(negedge clk); div_flush = 1'b1;
        @(posedge clk); #1; div_flush = 1'b0;
        chk("flush_done_drop", 32'(res_valid), 32'd0);
        chk("flush_done_idle", 32'(div_ready), 32'd1);

        // Flush and request together in IDLE: request dropped.
        @(negedge clk);
        div_req = 1'b1; div_flush = 1'b1; div_op = 2'd0; div_rs1 = 32'd5; div_rs2 = 32'd0;
        @(posedge clk); #1;
        div_req = 1'b0; div_flush = 1'b0;
        chk("idle_flush_ready", 32'(div_ready), 32'd1);
        chk("idle_flush_no_start", 32'(core_diven_p), 32'd0);
        chk("idle_flush_no_result", 32'(res_valid), 32'd0);

        // Asynchronous reset mid-WAIT.
        issue(2'd1, 32'd1000, 32'd3, 5'd9);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #2 cpurst = 1'b1;
        #1;
        chk("arst_ready", 32'(div_ready), 32'd1);
        chk("arst_diven", 32'(core_diven_p), 32'd0);
        chk("arst_dividend", core_dividend, 32'd0);
        chk("arst_divider", core_divider, 32'd0);
        chk("arst_res_data", res_data, 32'd0);
        chk("arst_res_valid", 32'(res_valid), 32'd0);
        #1 cpurst = 1'b0;
        do_op(2'd1, 32'd9, 32'd3, 5'd11, 32'd3, 32'd9, 32'd3, "post_reset");

        // Randomized operations against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rtag = 5'($urandom);
            ra   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                3: rb = 32'($urandom) >> $urandom_range(0, 31);
                default: rb = 32'($urandom);
            endcase
            do_op(rop, ra, rb, rtag, ref_result(rop, ra, rb), mag(rop, ra), mag(rop, rb),
                  $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
